ram_dump: RTL and testbench

RAM_DUMP -- requirements
Module: ram_dump

---
 rtl/ram_dump.sv | 173 +++++++++++++++++
 tb/tb_ram_dump.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dump.sv
// ram_dump: walks a RAM address range (inclusive, wrapping modulo the
// address space) and presents each word on a valid/ready output port.
// One word takes at least three enabled cycles: ADDR (address out),
// WAIT (RAM access), SEND (word held until accepted).
module ram_dump #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rw,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [ADDR_WIDTH-1:0] r_end;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_cur_nxt;
    logic [ADDR_WIDTH-1:0] w_end_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic                  w_out_valid_nxt;
    logic [ADDR_WIDTH-1:0] w_out_addr_nxt;
    logic [DATA_WIDTH-1:0] w_out_data_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [ADDR_WIDTH-1:0] w_cur_inc;

    assign w_cur_inc = r_cur + ADDR_ONE;

    // Next-state and next-register values; abort always wins over a transfer.
    always_comb begin
        w_state_nxt     = r_state;
        w_cur_nxt       = r_cur;
        w_end_nxt       = r_end;
        w_mem_addr_nxt  = r_mem_addr;
        w_out_valid_nxt = r_out_valid;
        w_out_addr_nxt  = r_out_addr;
        w_out_data_nxt  = r_out_data;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt    = S_ADDR;
                    w_cur_nxt      = start_addr;
                    w_end_nxt      = end_addr;
                    w_mem_addr_nxt = start_addr;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADDR: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt     = S_SEND;
                    w_out_data_nxt  = mem_data;
                    w_out_addr_nxt  = r_cur;
                    w_out_valid_nxt = 1'b1;
                end
            end
            S_SEND: begin
                if (abort) begin
                    w_state_nxt     = S_IDLE;
                    w_out_valid_nxt = 1'b0;
                end else if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (r_cur == r_end) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt    = S_ADDR;
                        w_cur_nxt      = w_cur_inc;
                        w_mem_addr_nxt = w_cur_inc;
                    end
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // Status flags are decoded from the next state so they leave registers.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_ADDR, S_WAIT, S_SEND: w_busy_nxt = 1'b1;
            S_DONE:                 w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers; everything holds on edges with clken low.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cur       <= ADDR_ZERO;
            r_end       <= ADDR_ZERO;
            r_mem_addr  <= ADDR_ZERO;
            r_out_valid <= 1'b0;
            r_out_addr  <= ADDR_ZERO;
            r_out_data  <= DATA_ZERO;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (clken) begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_end       <= w_end_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_out_data  <= w_out_data_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rw    = 1'b0;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_ram_dump.sv
// tb_ram_dump: directed dumps against a RAM preloaded with mem[i]=8'h10+i.
// Expected words are queued by the stimulus; a negedge monitor pops and
// compares on every transfer and checks output stability while stalled.
module tb_ram_dump;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       clken;
    logic       start;
    logic       abort;
    logic [3:0] start_addr;
    logic [3:0] end_addr;
    logic [3:0] mem_addr;
    logic       mem_rw;
    logic [7:0] mem_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_addr;
    logic [7:0] out_data;
    logic       busy;
    logic       done;

    ram_dump #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .sysclk(sysclk), .reset(reset), .clken(clken), .start(start),
        .abort(abort), .start_addr(start_addr), .end_addr(end_addr),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 sysclk = ~sysclk;

    // RAM model: synchronous read on enabled edges
    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    always @(posedge sysclk) if (clken) mem_data <= mem[mem_addr];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit rw_bad = 1'b0;
    logic [11:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_range(input logic [3:0] sa, input int n);
        logic [3:0] a;
        a = sa;
        for (int k = 0; k < n; k++) begin
            push(a, 8'h10 + {4'h0, a});
            a = a + 4'd1;
        end
    endtask

    // Monitor: transfers, stall stability, done pulses, mem_rw
    logic       p_have = 1'b0;
    logic       p_clken, p_valid, p_ready, p_abort, p_busy, p_done;
    logic [3:0] p_addr, p_maddr;
    logic [7:0] p_data;
    always @(negedge sysclk) begin
        if (!reset) begin
            p_have = 1'b0;
        end else begin
            if (mem_rw !== 1'b0) rw_bad = 1'b1;
            if (p_have) begin
                if (!p_clken) begin
                    chk("hold_clken0", {out_valid, out_addr, out_data, busy, done, mem_addr},
                        {p_valid, p_addr, p_data, p_busy, p_done, p_maddr});
                end else if (p_valid && !p_ready && !p_abort) begin
                    chk("hold_stall", {out_valid, out_addr, out_data}, {p_valid, p_addr, p_data});
                end
            end
            if (clken && out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {20'h0, out_addr, out_data}, 32'hFFFFFFFF);
                end else begin
                    chk("word", {20'h0, out_addr, out_data}, {20'h0, exp_q.pop_front()});
                end
            end
            if (clken && done) done_cnt++;
            p_have = 1'b1; p_clken = clken; p_valid = out_valid; p_ready = out_ready;
            p_abort = abort; p_busy = busy; p_done = done; p_addr = out_addr;
            p_data = out_data; p_maddr = mem_addr;
        end
    end

    // Optional clken toggling every 10 sysclk cycles
    bit tog_en = 1'b0;
    int tcnt = 0;
    initial forever begin
        @(posedge sysclk); #1;
        if (tog_en) begin
            tcnt++;
            if (tcnt == 10) begin clken = ~clken; tcnt = 0; end
        end
    end

    task automatic step();
        @(posedge sysclk); #1;
    endtask

    // Hold start until an enabled edge takes it
    task automatic issue_start(input logic [3:0] sa, input logic [3:0] ea);
        bit en;
        int n;
        start_addr = sa; end_addr = ea; start = 1'b1; n = 0;
        do begin
            @(negedge sysclk); en = clken;
            @(posedge sysclk); #1; n++;
        end while (!en && n < 100);
        start = 1'b0;
    endtask

    task automatic run_dump(input logic [3:0] sa, input logic [3:0] ea, input bit noise);
        int d0, n;
        d0 = done_cnt;
        issue_start(sa, ea);
        if (noise) begin
            start_addr = ~sa; end_addr = ~ea; start = 1'b1;
            step(); step();
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 2000) begin step(); n++; end
        if (n >= 2000) chk("done_timeout", 32'd0, 32'd1);
        chk("done_count", done_cnt, d0 + 1);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("idle_after_done", {busy, done, out_valid}, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; clken = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        start_addr = 4'h0; end_addr = 4'h0;
        #1;
        chk("reset_outputs", {mem_addr, mem_rw, out_valid, out_addr, out_data, busy, done}, 21'h0);
        step(); step();
        reset = 1'b1;
        step();

        // Basic range
        push(4'h0, 8'h10); push(4'h1, 8'h11); push(4'h2, 8'h12); push(4'h3, 8'h13);
        run_dump(4'd0, 4'd3, 1'b0);

        // Wrap past top of memory
        push(4'hE, 8'h1E); push(4'hF, 8'h1F); push(4'h0, 8'h10); push(4'h1, 8'h11);
        run_dump(4'd14, 4'd1, 1'b0);

        // Single word, then full 16-word wrap
        push(4'h5, 8'h15);
        run_dump(4'd5, 4'd5, 1'b0);
        push_range(4'd6, 16);
        run_dump(4'd6, 4'd5, 1'b0);

        // Consumer stall of 7 cycles on the second word
        push_range(4'd0, 4);
        fork
            run_dump(4'd0, 4'd3, 1'b0);
            begin
                int n;
                n = 0;
                while (!(out_valid && out_addr == 4'd1) && n < 200) begin step(); n++; end
                if (n >= 200) chk("stall_timeout", 32'd0, 32'd1);
                out_ready = 1'b0;
                repeat (7) step();
                out_ready = 1'b1;
            end
        join

        // start with abort in IDLE stays idle
        start_addr = 4'd2; end_addr = 4'd4; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        chk("start_abort_idle", {busy, out_valid}, 2'b00);

        // Address changes and start pulses while busy are ignored
        push_range(4'd2, 3);
        run_dump(4'd2, 4'd4, 1'b1);

        // Abort in SEND of the first word with out_ready=1
        begin
            int d0, n;
            d0 = done_cnt;
            issue_start(4'd3, 4'd6);
            n = 0;
            while (!out_valid && n < 100) begin step(); n++; end
            chk("abort_reach_send", {out_valid, out_addr}, {1'b1, 4'd3});
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_idle", {busy, out_valid, done}, 3'b000);
            repeat (3) step();
            chk("abort_no_done", done_cnt, d0);
            chk("abort_still_idle", {busy, out_valid}, 2'b00);
        end
        push_range(4'd3, 4);
        run_dump(4'd3, 4'd6, 1'b0);

        // Reset asserted mid-dump
        begin
            int d0;
            d0 = done_cnt;
            push_range(4'd0, 4);
            issue_start(4'd0, 4'd3);
            repeat (4) step();
            #2 reset = 1'b0;
            #1;
            chk("midreset_outputs", {mem_addr, mem_rw, out_valid, out_addr, out_data, busy, done}, 21'h0);
            exp_q.delete();
            step(); step();
            reset = 1'b1;
            repeat (6) step();
            chk("after_reset_idle", {busy, out_valid, done}, 3'b000);
            chk("after_reset_no_done", done_cnt, d0);
        end

        // clken toggling every 10 cycles gives the same sequences
        tog_en = 1'b1;
        push(4'h0, 8'h10); push(4'h1, 8'h11); push(4'h2, 8'h12); push(4'h3, 8'h13);
        run_dump(4'd0, 4'd3, 1'b0);
        push(4'hE, 8'h1E); push(4'hF, 8'h1F); push(4'h0, 8'h10); push(4'h1, 8'h11);
        run_dump(4'd14, 4'd1, 1'b0);
        tog_en = 1'b0;
        clken = 1'b1;
        step();

        chk("mem_rw_never_high", {31'h0, rw_bad}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
